// File: rtl/control_fsm.sv
// control_fsm
//   Multicycle sequencer for the RV64I core. Steps the shared datapath
//   through FETCH / DECODE / EXECUTE / MEMORY / WRITEBACK, one instruction
//   at a time, and handshakes with the unified memory port.
//
// Ports
//   i_clk            clock, rising edge
//   i_arstn          asynchronous active-low reset
//   i_op[6:0]        opcode from the instruction register
//   i_mem_ready      memory port completed the current request
//   o_mem_req        memory request, held until i_mem_ready
//   o_mem_we         memory write (valid with o_mem_req)
//   o_addr_src       memory address: 0 = PC, 1 = ALU result register
//   o_instr_we       load IR and old-PC register
//   o_pc_update      unconditional PC write
//   o_branch         conditional PC write (qualified by zero flag outside)
//   o_reg_we         register file write
//   o_alu_src_a[1:0] 00 PC, 01 old PC, 10 rs1, 11 zero
//   o_alu_src_b[1:0] 00 rs2, 01 immediate, 10 constant 4
//   o_alu_op[1:0]    00 add, 01 sub, 10 funct, 11 funct word
//   o_result_src[1:0] 00 ALU result reg, 01 memory data, 10 ALU output
//   o_illegal_instr  one-cycle pulse on an unsupported opcode (DECODE)
//   o_state[3:0]     current state, for debug
module control_fsm (
    input  logic       i_clk,
    input  logic       i_arstn,
    input  logic [6:0] i_op,
    input  logic       i_mem_ready,
    output logic       o_mem_req,
    output logic       o_mem_we,
    output logic       o_addr_src,
    output logic       o_instr_we,
    output logic       o_pc_update,
    output logic       o_branch,
    output logic       o_reg_we,
    output logic [1:0] o_alu_src_a,
    output logic [1:0] o_alu_src_b,
    output logic [1:0] o_alu_op,
    output logic [1:0] o_result_src,
    output logic       o_illegal_instr,
    output logic [3:0] o_state
);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADDR  = 4'd3,
        S_MEM_READ  = 4'd4,
        S_MEM_WB    = 4'd5,
        S_MEM_WRITE = 4'd6,
        S_EXEC_R    = 4'd7,
        S_EXEC_I    = 4'd8,
        S_LUI       = 4'd9,
        S_ALU_WB    = 4'd10,
        S_BRANCH    = 4'd11,
        S_JAL       = 4'd12,
        S_JALR      = 4'd13
    } state_t;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       addr_src;
        logic       pc_update;
        logic       branch;
        logic       reg_we;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] result_src;
    } ctrl_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_RW     = 7'b0111011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_IW     = 7'b0011011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    state_t state_q, state_d;
    ctrl_t  ctrl_q, ctrl_d;
    logic   op_legal;
    logic   fetch_done;

    always_comb begin
        op_legal = 1'b1;
        case (i_op)
            OP_LOAD, OP_STORE, OP_R, OP_RW, OP_I, OP_IW,
            OP_LUI, OP_AUIPC, OP_BRANCH, OP_JAL, OP_JALR: op_legal = 1'b1;
            default:                                      op_legal = 1'b0;
        endcase
    end

    // Next-state logic
    always_comb begin
        state_d = S_IDLE;
        case (state_q)
            S_IDLE:      state_d = S_FETCH;
            S_FETCH:     state_d = i_mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (i_op)
                    OP_LOAD, OP_STORE: state_d = S_MEM_ADDR;
                    OP_R, OP_RW:       state_d = S_EXEC_R;
                    OP_I, OP_IW:       state_d = S_EXEC_I;
                    OP_LUI:            state_d = S_LUI;
                    OP_AUIPC:          state_d = S_ALU_WB;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR;
                    default:           state_d = S_FETCH;
                endcase
            end
            S_MEM_ADDR:  state_d = (i_op == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:  state_d = i_mem_ready ? S_MEM_WB : S_MEM_READ;
            S_MEM_WB:    state_d = S_FETCH;
            S_MEM_WRITE: state_d = i_mem_ready ? S_FETCH : S_MEM_WRITE;
            S_EXEC_R:    state_d = S_ALU_WB;
            S_EXEC_I:    state_d = S_ALU_WB;
            S_LUI:       state_d = S_ALU_WB;
            S_ALU_WB:    state_d = S_FETCH;
            S_BRANCH:    state_d = S_FETCH;
            S_JAL:       state_d = S_ALU_WB;
            S_JALR:      state_d = S_JAL;
            default:     state_d = S_IDLE;
        endcase
    end

    // Moore outputs are decoded from the next state and registered, so each
    // register holds the decode of the state being entered. i_op is stable
    // from DECODE onward, which covers the EXEC alu_op selection.
    always_comb begin
        ctrl_d = '0;
        case (state_d)
            S_FETCH: begin
                ctrl_d.mem_req = 1'b1;
            end
            S_DECODE: begin
                ctrl_d.alu_src_a = 2'b01;
                ctrl_d.alu_src_b = 2'b01;
            end
            S_MEM_ADDR: begin
                ctrl_d.alu_src_a = 2'b10;
                ctrl_d.alu_src_b = 2'b01;
            end
            S_MEM_READ: begin
                ctrl_d.mem_req  = 1'b1;
                ctrl_d.addr_src = 1'b1;
            end
            S_MEM_WB: begin
                ctrl_d.result_src = 2'b01;
                ctrl_d.reg_we     = 1'b1;
            end
            S_MEM_WRITE: begin
                ctrl_d.mem_req  = 1'b1;
                ctrl_d.mem_we   = 1'b1;
                ctrl_d.addr_src = 1'b1;
            end
            S_EXEC_R: begin
                ctrl_d.alu_src_a = 2'b10;
                ctrl_d.alu_src_b = 2'b00;
                ctrl_d.alu_op    = {1'b1, i_op[3]};
            end
            S_EXEC_I: begin
                ctrl_d.alu_src_a = 2'b10;
                ctrl_d.alu_src_b = 2'b01;
                ctrl_d.alu_op    = {1'b1, i_op[3]};
            end
            S_LUI: begin
                ctrl_d.alu_src_a = 2'b11;
                ctrl_d.alu_src_b = 2'b01;
            end
            S_ALU_WB: begin
                ctrl_d.reg_we = 1'b1;
            end
            S_BRANCH: begin
                ctrl_d.alu_src_a = 2'b10;
                ctrl_d.alu_src_b = 2'b00;
                ctrl_d.alu_op    = 2'b01;
                ctrl_d.branch    = 1'b1;
            end
            S_JAL: begin
                ctrl_d.pc_update = 1'b1;
                ctrl_d.alu_src_a = 2'b01;
                ctrl_d.alu_src_b = 2'b10;
            end
            S_JALR: begin
                ctrl_d.alu_src_a = 2'b10;
                ctrl_d.alu_src_b = 2'b01;
            end
            default: ctrl_d = '0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_arstn) begin
        if (!i_arstn) begin
            state_q <= S_IDLE;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
        end
    end

    // FETCH completion strobes follow i_mem_ready combinationally so the IR
    // and PC are written in the same cycle the fetch data is returned.
    assign fetch_done = (state_q == S_FETCH) && i_mem_ready;

    assign o_mem_req       = ctrl_q.mem_req;
    assign o_mem_we        = ctrl_q.mem_we;
    assign o_addr_src      = ctrl_q.addr_src;
    assign o_instr_we      = fetch_done;
    assign o_pc_update     = ctrl_q.pc_update | fetch_done;
    assign o_branch        = ctrl_q.branch;
    assign o_reg_we        = ctrl_q.reg_we;
    assign o_alu_src_a     = ctrl_q.alu_src_a;
    assign o_alu_src_b     = fetch_done ? 2'b10 : ctrl_q.alu_src_b;
    assign o_alu_op        = ctrl_q.alu_op;
    assign o_result_src    = fetch_done ? 2'b10 : ctrl_q.result_src;
    assign o_illegal_instr = (state_q == S_DECODE) && !op_legal;
    assign o_state         = state_q;

endmodule
